regfile_write_arbiter: RTL and testbench

//   Shares the single write port of the register file among NREQ requesters with

---
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Zero-fills the register file after reset and on clear_start, then grants requesters.
module regfile_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  clear_start,
  output logic                  init_done,
  output logic                  rf_wr_en,
  output logic [AW-1:0]         rf_wr_addr,
  output logic [WIDTH-1:0]      rf_wr_data
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic            clr_last;

  assign clr_last  = (clr_cnt == AW'(DEPTH - 1));
  assign init_done = (state == ST_RUN);
  assign req_ready = grant;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % NREQ);
  endfunction

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (state == ST_RUN && !clear_start) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[rr_index(rr_ptr, k)]) begin
          grant_idx = rr_index(rr_ptr, k);
          grant_any = 1'b1;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_last)    state_next = ST_RUN;
      ST_RUN:   if (clear_start) state_next = ST_CLEAR;
      default:                   state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt    <= '0;
      rr_ptr     <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (state == ST_CLEAR) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= clr_cnt;
      rf_wr_data <= '0;
      clr_cnt    <= clr_last ? '0 : clr_cnt + 1'b1;
    end else if (clear_start) begin
      clr_cnt  <= '0;
      rf_wr_en <= 1'b0;
    end else if (grant_any) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= sel_addr;
      rf_wr_data <= sel_data;
      rr_ptr     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      // Idle cycle: address and data hold their last values.
      rf_wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued when
// stimulus is driven and popped by a monitor as the DUT issues them.
module tb_regfile_write_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NREQ  = 4;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  clear_start;
  logic                  init_done;
  logic                  rf_wr_en;
  logic [AW-1:0]         rf_wr_addr;
  logic [WIDTH-1:0]      rf_wr_data;

  wr_t              exp_q[$];
  wr_t              mon_exp;
  logic [AW-1:0]    addr_v[NREQ];
  logic [WIDTH-1:0] data_v[NREQ];
  int               m_rr;
  logic             m_run;
  logic [AW-1:0]    m_last_addr;
  logic [WIDTH-1:0] m_last_data;
  int               errors;
  int               checks;

  regfile_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .init_done   (init_done),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every issued write must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && rf_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write: got addr=%0d data=%h, expected no write", rf_wr_addr, rf_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rf_wr_addr !== mon_exp.addr || rf_wr_data !== mon_exp.data) begin
          errors++;
          $display("FAIL write_payload: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_wr_addr, rf_wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]       = addr_v[i];
      req_data[i*WIDTH +: WIDTH] = data_v[i];
    end
  endtask

  // One RUN-side cycle: model the grant, queue the write, check handshake and write strobe.
  task automatic run_cycle(input logic [NREQ-1:0] v, input logic clr);
    logic [NREQ-1:0] eg;
    int g;
    req_valid   = v;
    clear_start = clr;
    pack();
    #1;
    eg = '0;
    g  = -1;
    if (m_run && !clr) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      exp_q.push_back('{addr: addr_v[g], data: data_v[g]});
    end
    checks++;
    if (req_ready !== eg) begin
      errors++;
      $display("FAIL req_ready: got %b, expected %b", req_ready, eg);
    end
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    if (clr) m_run = 1'b0;
    checks++;
    if (rf_wr_en !== (g >= 0)) begin
      errors++;
      $display("FAIL wr_en: got %b, expected %b", rf_wr_en, (g >= 0));
    end
    checks++;
    if (init_done !== m_run) begin
      errors++;
      $display("FAIL init_done_run: got %b, expected %b", init_done, m_run);
    end
    if (g >= 0) begin
      m_rr        = (g + 1) % NREQ;
      m_last_addr = addr_v[g];
      m_last_data = data_v[g];
      addr_v[g]   = AW'($urandom_range(0, DEPTH - 1));
      data_v[g]   = $urandom;
    end else begin
      checks++;
      if (rf_wr_addr !== m_last_addr || rf_wr_data !== m_last_data) begin
        errors++;
        $display("FAIL idle_hold: got addr=%0d data=%h, expected addr=%0d data=%h",
                 rf_wr_addr, rf_wr_data, m_last_addr, m_last_data);
      end
    end
    pack();
  endtask

  // Full zero-fill: DEPTH back-to-back writes, no grants, init_done rising with the last one.
  task automatic clear_phase();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), data: '0});
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL clear_ready: cycle %0d got %b, expected 0", i, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rf_wr_en !== 1'b1 || init_done !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL clear_cycle: cycle %0d got en=%b init_done=%b, expected en=1 init_done=%b",
                 i, rf_wr_en, init_done, (i == DEPTH - 1));
      end
    end
    m_run       = 1'b1;
    m_last_addr = AW'(DEPTH - 1);
    m_last_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    #12;
    checks++;
    if (rf_wr_en !== 1'b0 || init_done !== 1'b0 || req_ready !== '0 ||
        rf_wr_addr !== '0 || rf_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%b done=%b ready=%b addr=%0d data=%h, expected all 0",
               rf_wr_en, init_done, req_ready, rf_wr_addr, rf_wr_data);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_phase();
    run_cycle(4'b0000, 1'b0);
  endtask

  task automatic test_single();
    addr_v[2] = 5'd7;
    data_v[2] = 32'hDEADBEEF;
    run_cycle(4'b0100, 1'b0);
    run_cycle(4'b0000, 1'b0);
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < NREQ; i++) begin
      addr_v[i] = AW'(10 + i);
      data_v[i] = 32'hA000_0000 + 32'(i);
    end
    for (int c = 0; c < 8; c++) run_cycle(4'b1111, 1'b0);
    run_cycle(4'b0000, 1'b0);
  endtask

  task automatic test_clear_start();
    addr_v[1] = 5'd20;
    data_v[1] = 32'h1234_5678;
    run_cycle(4'b0010, 1'b1);
    clear_phase();
    run_cycle(4'b0010, 1'b0);
    run_cycle(4'b0000, 1'b0);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    m_rr  = 0;
    m_run = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), data: '0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_wr_en !== 1'b0 || init_done !== 1'b0 || rf_wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_abort: got en=%b done=%b addr=%0d, expected 0 0 0",
               rf_wr_en, init_done, rf_wr_addr);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    clear_phase();
  endtask

  task automatic test_rr_wrap();
    addr_v[2] = 5'd3;
    data_v[2] = 32'h2222_0000;
    run_cycle(4'b0100, 1'b0);
    addr_v[3] = 5'd30;
    data_v[3] = 32'h3333_3333;
    addr_v[0] = 5'd1;
    data_v[0] = 32'h0000_0001;
    run_cycle(4'b1001, 1'b0);
    run_cycle(4'b0001, 1'b0);
    addr_v[3] = 5'd29;
    data_v[3] = 32'h3030_3030;
    run_cycle(4'b1001, 1'b0);
    run_cycle(4'b1000, 1'b0);
  endtask

  task automatic test_back_to_back();
    addr_v[0] = 5'd9;
    data_v[0] = 32'hAAAA_AAAA;
    addr_v[1] = 5'd9;
    data_v[1] = 32'hBBBB_BBBB;
    run_cycle(4'b0011, 1'b0);
    addr_v[0] = 5'd9;
    addr_v[1] = 5'd9;
    run_cycle(4'b0011, 1'b0);
    run_cycle(4'b0000, 1'b0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    m_rr        = 0;
    m_run       = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
    clear_start = 1'b0;
    req_valid   = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_v[i] = '0;
      data_v[i] = '0;
    end
    pack();
    test_reset();
    test_single();
    test_all_valid();
    test_clear_start();
    test_reset_abort();
    test_rr_wrap();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
